// File: rtl/approx_err_monitor.sv
// Streaming error-statistics monitor placed behind a WxW approximate multiplier.
// Stage 1 recomputes the exact product; stage 2 accumulates signed/absolute error statistics.
module approx_err_monitor #(
  parameter int W     = 6,
  parameter int NSAMP = 4096,
  parameter int ACC_W = 25
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W-1:0]              in_a,
  input  logic [W-1:0]              in_b,
  input  logic [2*W-1:0]            in_prod,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NSAMP):0]    err_count,
  output logic signed [ACC_W-1:0]   err_sum,
  output logic [ACC_W-1:0]          abs_sum,
  output logic [2*W-1:0]            max_abs,
  output logic signed [ACC_W-1:0]   mean_err
);

  localparam int LOG2N = $clog2(NSAMP);
  localparam int CNT_W = LOG2N + 1;
  localparam int PW    = 2 * W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic             accept;
  logic             last_accept;
  logic             start_ok;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;

  logic [PW-1:0]    exact_p0;
  logic             vld_p1_q;
  logic [PW-1:0]    exact_p1_q;
  logic [PW-1:0]    prod_p1_q;

  logic signed [PW:0]      diff_p1;
  logic [PW-1:0]           abs_p1;
  logic signed [ACC_W-1:0] diff_ext_p1;

  logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;
  logic signed [ACC_W-1:0] err_sum_q, err_sum_d;
  logic [ACC_W-1:0]        abs_sum_q, abs_sum_d;
  logic [PW-1:0]           max_abs_q, max_abs_d;

  function automatic logic signed [PW:0] calc_diff(input logic [PW-1:0] prod,
                                                   input logic [PW-1:0] exact);
    calc_diff = $signed({1'b0, prod}) - $signed({1'b0, exact});
  endfunction

  // |diff| always fits in PW bits because both operands are PW-bit unsigned.
  function automatic logic [PW-1:0] calc_abs(input logic signed [PW:0] d);
    logic signed [PW:0] mag;
    mag = d[PW] ? -d : d;
    calc_abs = mag[PW-1:0];
  endfunction

  assign accept      = in_valid & in_ready;
  assign last_accept = accept && (sample_cnt_q == CNT_W'(NSAMP - 1));
  assign start_ok    = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_accept) state_d = S_DRAIN;
      S_DRAIN: if (!vld_p1_q) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_RUN);
    busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    done     = (state_q == S_DONE);
  end

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    if (start_ok) begin
      sample_cnt_d = '0;
    end else if (accept) begin
      sample_cnt_d = sample_cnt_q + CNT_W'(1);
    end
  end

  // ---- stage 0 -> 1: exact product recompute ----
  assign exact_p0 = {{W{1'b0}}, in_a} * {{W{1'b0}}, in_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      exact_p1_q <= exact_p0;
      prod_p1_q  <= in_prod;
    end
  end

  // ---- stage 1 -> 2: error accumulation ----
  assign diff_p1     = calc_diff(prod_p1_q, exact_p1_q);
  assign abs_p1      = calc_abs(diff_p1);
  assign diff_ext_p1 = {{(ACC_W-PW-1){diff_p1[PW]}}, diff_p1};

  always_comb begin
    err_cnt_d = err_cnt_q;
    err_sum_d = err_sum_q;
    abs_sum_d = abs_sum_q;
    max_abs_d = max_abs_q;
    if (start_ok) begin
      err_cnt_d = '0;
      err_sum_d = '0;
      abs_sum_d = '0;
      max_abs_d = '0;
    end else if (vld_p1_q) begin
      if (diff_p1 != '0) err_cnt_d = err_cnt_q + CNT_W'(1);
      err_sum_d = err_sum_q + diff_ext_p1;
      abs_sum_d = abs_sum_q + {{(ACC_W-PW){1'b0}}, abs_p1};
      if (abs_p1 > max_abs_q) max_abs_d = abs_p1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
      err_sum_q <= '0;
      abs_sum_q <= '0;
      max_abs_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      err_sum_q <= err_sum_d;
      abs_sum_q <= abs_sum_d;
      max_abs_q <= max_abs_d;
    end
  end

  assign err_count = err_cnt_q;
  assign err_sum   = err_sum_q;
  assign abs_sum   = abs_sum_q;
  assign max_abs   = max_abs_q;
  // Arithmetic shift floors toward minus infinity.
  assign mean_err  = err_sum_q >>> LOG2N;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Scoreboard bench for approx_err_monitor: stimulus computes expected run statistics,
// a negedge monitor pops them when done rises and checks them while done is held.
module tb_approx_err_monitor;
  localparam int W     = 6;
  localparam int N     = 4096;
  localparam int ACC_W = 25;
  localparam int LOG2N = 12;

  logic                    clk = 1'b0;
  logic                    rst, start, in_valid;
  logic [W-1:0]            in_a, in_b;
  logic [2*W-1:0]          in_prod;
  logic                    in_ready, busy, done;
  logic [LOG2N:0]          err_count;
  logic signed [ACC_W-1:0] err_sum, mean_err;
  logic [ACC_W-1:0]        abs_sum;
  logic [2*W-1:0]          max_abs;

  approx_err_monitor #(.W(W), .NSAMP(N), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_prod(in_prod), .busy(busy), .done(done),
    .err_count(err_count), .err_sum(err_sum), .abs_sum(abs_sum),
    .max_abs(max_abs), .mean_err(mean_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int cnt;
    int sum;
    int abs_s;
    int mx;
    int mean;
    int done_edge;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pop on done rising, then hold-check every cycle done stays high.
  exp_t cur;
  bit   have_cur = 1'b0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: done rose at cycle %0d, no run expected", cyc);
        have_cur = 1'b0;
      end else begin
        cur = sb_q.pop_front();
        have_cur = 1'b1;
        chk("done_edge", cyc, cur.done_edge);
      end
    end
    if (done && have_cur) begin
      chk("err_count", err_count, cur.cnt);
      chk("err_sum", err_sum, cur.sum);
      chk("abs_sum", abs_sum, cur.abs_s);
      chk("max_abs", max_abs, cur.mx);
      chk("mean_err", mean_err, cur.mean);
    end
    if (!done) have_cur = 1'b0;
    done_prev = done;
  end

  task automatic check_zero(input string pfx);
    chk({pfx, "_in_ready"}, in_ready, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_err_count"}, err_count, 0);
    chk({pfx, "_err_sum"}, err_sum, 0);
    chk({pfx, "_abs_sum"}, abs_sum, 0);
    chk({pfx, "_max_abs"}, max_abs, 0);
    chk({pfx, "_mean_err"}, mean_err, 0);
  endtask

  // Called #1 after an edge; consumes the start edge.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_ready", in_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_err_count", err_count, 0);
    chk("start_err_sum", err_sum, 0);
    chk("start_abs_sum", abs_sum, 0);
    chk("start_max_abs", max_abs, 0);
  endtask

  // kind: 0 exact, 1 offset +1, 2 truncate low 2 bits, 3 random operands with random faults
  task automatic drive_run(input int kind, input int n, input bit gaps,
                           input int start_pulse_at, output exp_t e);
    int cnt, sum, abs_s, mx, last_edge;
    cnt = 0; sum = 0; abs_s = 0; mx = 0; last_edge = 0;
    for (int idx = 0; idx < n; idx++) begin
      logic [W-1:0] a, b;
      int ex, p, d, guard;
      bit acc;
      if (kind == 3) begin
        a = W'($urandom_range(0, 63));
        b = W'($urandom_range(0, 63));
      end else begin
        a = W'(idx >> 6);
        b = W'(idx & 63);
      end
      ex = int'(a) * int'(b);
      case (kind)
        0: p = ex;
        1: p = ex + 1;
        2: p = ex & ~3;
        default: p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : ex;
      endcase
      acc = 1'b0;
      guard = 0;
      while (!acc) begin
        in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        in_a = a;
        in_b = b;
        in_prod = p[2*W-1:0];
        start = (idx == start_pulse_at);
        if (in_valid && in_ready) begin
          acc = 1'b1;
          last_edge = cyc + 1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        guard++;
        if (!acc && guard > 100) begin
          miscompares++;
          $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, guard);
          $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
          $fatal(1);
        end
      end
      d = p - ex;
      if (d != 0) cnt++;
      sum += d;
      abs_s += (d < 0) ? -d : d;
      if (((d < 0) ? -d : d) > mx) mx = (d < 0) ? -d : d;
    end
    e.cnt = cnt;
    e.sum = sum;
    e.abs_s = abs_s;
    e.mx = mx;
    e.mean = (sum >= 0) ? sum / N : -((-sum + N - 1) / N);
    e.done_edge = last_edge + 2;
  endtask

  // Entered #1 after the last-accept edge k: push expectation, then check DRAIN/DONE handshake.
  task automatic post_run(input exp_t e);
    sb_q.push_back(e);
    in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk("drain_in_ready", in_ready, 0);
      chk("drain_busy", busy, (j < 2) ? 1 : 0);
      chk("drain_done", done, (j == 2) ? 1 : 0);
      if (j < 2) begin
        @(posedge clk); #1;
      end
    end
    repeat (3) begin
      @(posedge clk); #1;
      chk("done_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_prod = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_zero("idle");

    for (int k = 0; k < 3; k++) begin
      do_start();
      drive_run(k, N, 1'b0, -1, e);
      post_run(e);
    end

    // Bubbles plus an ignored start pulse mid-run.
    do_start();
    drive_run(1, N, 1'b1, 2000, e);
    post_run(e);

    do_start();
    drive_run(3, N, 1'b1, -1, e);
    post_run(e);

    // Abort a run with an asynchronous reset, then a clean exact run.
    do_start();
    drive_run(1, 100, 1'b0, -1, e);
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_zero("post_rst");
    do_start();
    drive_run(0, N, 1'b0, -1, e);
    post_run(e);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
